// File: rtl/sdes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sdes_pkg
// Purpose : Shared S-DES definitions for the sequential decrypt engine:
//           FSM state encoding, permutation index tables, S-boxes and
//           the permute / half-rotate helper functions.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package sdes_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEYGEN   = 3'd1,
        S_ROUND_K2 = 3'd2,
        S_ROUND_K1 = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Permutation tables, 1-based source positions with position 1 = MSB.
    // Every table is padded to 10 entries at the high end so one helper
    // can serve all widths; entry [n_out-1] is the first output bit.
    localparam logic [9:0][3:0] c_P10    = {4'd3, 4'd5, 4'd2, 4'd7, 4'd4,
                                            4'd10, 4'd1, 4'd9, 4'd8, 4'd6};
    localparam logic [9:0][3:0] c_P8     = {{2{4'd0}}, 4'd6, 4'd3, 4'd7, 4'd4,
                                            4'd8, 4'd5, 4'd10, 4'd9};
    localparam logic [9:0][3:0] c_IP     = {{2{4'd0}}, 4'd2, 4'd6, 4'd3, 4'd1,
                                            4'd4, 4'd8, 4'd5, 4'd7};
    localparam logic [9:0][3:0] c_IP_INV = {{2{4'd0}}, 4'd4, 4'd1, 4'd3, 4'd5,
                                            4'd7, 4'd2, 4'd8, 4'd6};
    localparam logic [9:0][3:0] c_EP     = {{2{4'd0}}, 4'd4, 4'd1, 4'd2, 4'd3,
                                            4'd2, 4'd3, 4'd4, 4'd1};
    localparam logic [9:0][3:0] c_P4     = {{6{4'd0}}, 4'd2, 4'd4, 4'd3, 4'd1};

    // S-boxes flattened as row*4 + col.
    localparam logic [1:0] c_S0 [16] = '{2'd1, 2'd0, 2'd3, 2'd2,
                                         2'd3, 2'd2, 2'd1, 2'd0,
                                         2'd0, 2'd2, 2'd1, 2'd3,
                                         2'd3, 2'd1, 2'd3, 2'd2};
    localparam logic [1:0] c_S1 [16] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                         2'd2, 2'd0, 2'd1, 2'd3,
                                         2'd3, 2'd0, 2'd1, 2'd0,
                                         2'd2, 2'd1, 2'd0, 2'd3};

    // Generic bit permutation: input is n_in bits right-aligned in din,
    // result is n_out bits right-aligned in the return value.
    function automatic logic [9:0] permute(input logic [9:0] din, input int n_in,
                                           input logic [9:0][3:0] tbl, input int n_out);
        logic [9:0] dout;
        logic [3:0] idx;
        dout = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < n_out) begin
                idx     = 4'(n_in - int'(tbl[i]));
                dout[i] = din[idx];
            end
        end
        return dout;
    endfunction

    // Rotate each 5-bit half of a 10-bit key left by n places.
    function automatic logic [9:0] ls10(input logic [9:0] k, input int n);
        logic [4:0] l;
        logic [4:0] r;
        l = k[9:5];
        r = k[4:0];
        for (int i = 0; i < n; i++) begin
            l = {l[3:0], l[4]};
            r = {r[3:0], r[4]};
        end
        return {l, r};
    endfunction

    // Row from outer bits (1,4), column from inner bits (2,3).
    function automatic logic [1:0] sbox(input logic [3:0] x, input logic sel_s1);
        logic [3:0] idx;
        idx = {x[3], x[0], x[2], x[1]};
        return sel_s1 ? c_S1[idx] : c_S0[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdes_decrypt_seq_fk_round.sv
`default_nettype none
// ============================================================================
// Module  : sdes_fk_round
// Purpose : Combinational S-DES round function fK(L,R,K) = (L ^ F(R,K), R).
// Ports   : i_data   [7:0] - round input {L,R}
//           i_subkey [7:0] - round subkey
//           o_data   [7:0] - round output {L ^ F(R,K), R}
// Revision: 1.0 - initial release
// ============================================================================
module sdes_fk_round
    import sdes_pkg::*;
(
    input  logic [7:0] i_data,
    input  logic [7:0] i_subkey,
    output logic [7:0] o_data
);

    logic [7:0] w_ep;
    logic [3:0] w_sbox;
    logic [3:0] w_f;

    assign w_ep   = 8'(permute(10'(i_data[3:0]), 4, c_EP, 8)) ^ i_subkey;
    assign w_sbox = {sbox(w_ep[7:4], 1'b0), sbox(w_ep[3:0], 1'b1)};
    assign w_f    = 4'(permute(10'(w_sbox), 4, c_P4, 4));
    assign o_data = {i_data[7:4] ^ w_f, i_data[3:0]};

endmodule
`default_nettype wire

// File: rtl/sdes_decrypt_seq.sv
`default_nettype none
// ============================================================================
// Module  : sdes_decrypt_seq
// Purpose : Multi-cycle handshaked S-DES decryption engine.
//           IDLE -> KEYGEN -> ROUND_K2 -> ROUND_K1 -> DONE -> IDLE.
//           One shared fK instance, subkey selected by state.
// Ports   : CLOCK_50          - clock, rising edge
//           reset             - synchronous active-high reset
//           in_valid/in_ready - input handshake (ready only in IDLE)
//           ciphertext [7:0], key [9:0] - captured on accept
//           out_valid/out_ready - output handshake, held until taken
//           plaintext [7:0]   - registered result, stable while out_valid
//           busy              - high whenever not IDLE
//           iv [7:0], iv_load - chaining IV load (SDES_DEC_CBC_EN only)
// Config  : SDES_DEC_CBC_EN - enables CBC chaining on decrypt output
// Revision: 1.0 - initial release
// ============================================================================
module sdes_decrypt_seq
    import sdes_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] ciphertext,
    input  logic [9:0] key,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] plaintext,
    output logic       busy
`ifdef SDES_DEC_CBC_EN
    ,
    input  logic [7:0] iv,
    input  logic       iv_load
`endif
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_key;
    logic [7:0] r_k1;
    logic [7:0] r_k2;
    logic [7:0] r_data;
    logic       r_out_valid;

    logic [9:0] w_p10;
    logic [7:0] w_k1;
    logic [7:0] w_k2;
    logic [7:0] w_fk_key;
    logic [7:0] w_fk_out;
    logic [7:0] w_final;
    logic       w_accept;
    logic       w_iv_load;

`ifdef SDES_DEC_CBC_EN
    logic [7:0] r_chain;
    logic [7:0] r_ct;

    // IV load wins over a same-cycle in_valid, which then stays unaccepted.
    assign w_iv_load = iv_load && (r_state == S_IDLE);
    assign w_final   = 8'(permute(10'(w_fk_out), 8, c_IP_INV, 8)) ^ r_chain;
`else
    assign w_iv_load = 1'b0;
    assign w_final   = 8'(permute(10'(w_fk_out), 8, c_IP_INV, 8));
`endif

    assign w_accept  = in_valid && (r_state == S_IDLE) && !w_iv_load;
    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign plaintext = r_data;

    // Key schedule is evaluated from the captured key during KEYGEN only.
    assign w_p10 = permute(r_key, 10, c_P10, 10);
    assign w_k1  = 8'(permute(ls10(w_p10, 1), 10, c_P8, 8));
    assign w_k2  = 8'(permute(ls10(w_p10, 3), 10, c_P8, 8));

    // Decryption applies K2 first, then K1.
    assign w_fk_key = (r_state == S_ROUND_K1) ? r_k1 : r_k2;

    sdes_fk_round u_fk (
        .i_data   (r_data),
        .i_subkey (w_fk_key),
        .o_data   (w_fk_out)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_nxt = S_KEYGEN;
            S_KEYGEN:   w_state_nxt = S_ROUND_K2;
            S_ROUND_K2: w_state_nxt = S_ROUND_K1;
            S_ROUND_K1: w_state_nxt = S_DONE;
            S_DONE:     if (out_ready) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_key       <= '0;
            r_k1        <= '0;
            r_k2        <= '0;
            r_data      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_key  <= key;
                        r_data <= ciphertext;
                    end
                end
                S_KEYGEN: begin
                    r_k1   <= w_k1;
                    r_k2   <= w_k2;
                    r_data <= 8'(permute(10'(r_data), 8, c_IP, 8));
                end
                S_ROUND_K2: begin
                    r_data <= {w_fk_out[3:0], w_fk_out[7:4]};
                end
                S_ROUND_K1: begin
                    r_data      <= w_final;
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SDES_DEC_CBC_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_chain <= '0;
            r_ct    <= '0;
        end else begin
            if (w_iv_load) begin
                r_chain <= iv;
            end else if (w_accept) begin
                r_ct <= ciphertext;
            end
            if (r_state == S_ROUND_K1) r_chain <= r_ct;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdes_decrypt_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_sdes_decrypt_seq
// Purpose : Self-checking bench for sdes_decrypt_seq: known-answer table,
//           hold/back-pressure, reset mid-operation, random back-to-back
//           traffic against an arithmetic S-DES reference model.
//           SDES_DEC_CBC_EN selects the chained build checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sdes_decrypt_seq;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ciphertext;
    logic [9:0] key;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] plaintext;
    logic       busy;
`ifdef SDES_DEC_CBC_EN
    logic [7:0] iv;
    logic       iv_load;
`endif

    always #5 CLOCK_50 = ~CLOCK_50;

    sdes_decrypt_seq dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
`ifdef SDES_DEC_CBC_EN
        ,
        .iv         (iv),
        .iv_load    (iv_load)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] m_chain = 8'h00;

    // ---------------- reference model (1-based bit positions) ----------------
    int P10[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    int P8 [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    int IPT[10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    int IPI[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    int EPT[10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    int P4T[10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
    int S0[4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    int S1[4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    function automatic int perm(input int x, input int nin, input int tbl[10], input int nout);
        int r;
        r = 0;
        for (int j = 0; j < nout; j++) r = (r << 1) | ((x >> (nin - tbl[j])) & 1);
        return r;
    endfunction

    function automatic int rotl5(input int v, input int n);
        return ((v << n) | (v >> (5 - n))) & 31;
    endfunction

    function automatic int sbox_lookup(input int t, input bit use_s1);
        int row;
        int col;
        row = ((t >> 3) & 1) * 2 + (t & 1);
        col = ((t >> 2) & 1) * 2 + ((t >> 1) & 1);
        return use_s1 ? S1[row][col] : S0[row][col];
    endfunction

    function automatic int fk(input int d, input int k);
        int t;
        int f;
        t = perm(d & 15, 4, EPT, 8) ^ k;
        f = perm(sbox_lookup(t >> 4, 1'b0) * 4 + sbox_lookup(t & 15, 1'b1), 4, P4T, 4);
        return (((d >> 4) ^ f) << 4) | (d & 15);
    endfunction

    function automatic logic [7:0] model_decrypt(input logic [7:0] ct, input logic [9:0] k,
                                                 input logic [7:0] chain);
        int p;
        int k1;
        int k2;
        int d;
        p  = perm(int'(k), 10, P10, 10);
        k1 = perm((rotl5(p >> 5, 1) << 5) | rotl5(p & 31, 1), 10, P8, 8);
        k2 = perm((rotl5(p >> 5, 3) << 5) | rotl5(p & 31, 3), 10, P8, 8);
        d  = perm(int'(ct), 8, IPT, 8);
        d  = fk(d, k2);
        d  = ((d & 15) << 4) | (d >> 4);
        d  = fk(d, k1);
        return 8'(perm(d, 8, IPI, 8)) ^ chain;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one block and complete it, holding out_ready low for 'hold' DONE cycles.
    // Called and returns just after a falling edge.
    task automatic run_op(input logic [7:0] ct, input logic [9:0] k, input logic [7:0] pt_ecb,
                          input int hold, input string name);
        logic [7:0] exp;
        int waited;
        int lat;
        exp = pt_ecb ^ m_chain;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge CLOCK_50);
            waited++;
        end
        check({name, " ready"}, in_ready, 1);
        ciphertext = ct;
        key        = k;
        in_valid   = 1'b1;
        out_ready  = (hold == 0);
        @(negedge CLOCK_50);
        in_valid   = 1'b0;
        ciphertext = 8'($urandom);
        key        = 10'($urandom);
        check({name, " busy"}, {busy, in_ready}, 2'b10);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge CLOCK_50);
            lat++;
        end
        // out_valid seen at the falling edge after edge N+lat is sampled at edge N+lat+1
        check({name, " latency"}, lat + 1, 4);
        check({name, " pt"}, plaintext, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid   = 1'b1;
            ciphertext = 8'($urandom);
            key        = 10'($urandom);
            @(negedge CLOCK_50);
            check({name, " hold"}, {out_valid, in_ready, plaintext}, {2'b10, exp});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLOCK_50);
        check({name, " release"}, {in_ready, out_valid, busy}, 3'b100);
`ifdef SDES_DEC_CBC_EN
        m_chain = ct;
`endif
    endtask

    typedef struct {
        logic [9:0] k;
        logic [7:0] ct;
        logic [7:0] pt;
        int         hold;
        string      name;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_pt;
        logic [7:0] rct;
        logic [9:0] rkey;
        int last;
        int seen_ov;

        vecs[0] = '{10'b1010000010, 8'h38,        8'h97, 0,  "kat0"};
        vecs[1] = '{10'h000,        8'b00010001,  8'hAA, 0,  "kat1"};
        vecs[2] = '{10'b1110001110, 8'b01110000,  8'h55, 0,  "kat2"};
        vecs[3] = '{10'b1010000010, 8'h38,        8'h97, 10, "hold10"};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ciphertext = 8'h00; key = 10'h000;
`ifdef SDES_DEC_CBC_EN
        iv = 8'h00; iv_load = 1'b0;
`endif
        repeat (3) @(negedge CLOCK_50);
        check("reset state", {in_ready, out_valid, busy, plaintext}, {3'b100, 8'h00});
        reset = 1'b0;
        @(negedge CLOCK_50);

        // Known-answer table
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].ct, vecs[i].k, vecs[i].pt, vecs[i].hold, vecs[i].name);
            if (i == 0) check("subkeys K1,K2", {dut.r_k1, dut.r_k2}, 16'hA443);
        end

        // Reset while in ROUND_K2 discards the operation
        ciphertext = 8'h38; key = 10'b1010000010; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        @(negedge CLOCK_50);
        check("rst mid busy", busy, 1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        m_chain = 8'h00;
        check("rst mid state", {in_ready, out_valid, busy}, 3'b100);
        seen_ov = 0;
        repeat (6) begin
            @(negedge CLOCK_50);
            if (out_valid) seen_ov++;
        end
        check("rst no output", seen_ov, 0);
        run_op(8'h38, 10'b1010000010, 8'h97, 0, "after rst");

`ifdef SDES_DEC_CBC_EN
        // iv_load takes priority over a same-cycle in_valid
        iv = 8'h00; iv_load = 1'b1; in_valid = 1'b1;
        ciphertext = 8'h38; key = 10'b1010000010;
        @(negedge CLOCK_50);
        iv_load = 1'b0; in_valid = 1'b0;
        check("iv_load no accept", {in_ready, busy}, 2'b10);
        m_chain = 8'h00;
        run_op(8'h38, 10'b1010000010, 8'h97, 0, "cbc blk0");
        check("cbc chain ref", m_chain ^ 8'h97, 8'hAF);
        run_op(8'h38, 10'b1010000010, 8'h97, 0, "cbc blk1");
`endif

        // Random single ops with random back-pressure
        for (int i = 0; i < 8; i++) begin
            rct  = 8'($urandom);
            rkey = 10'($urandom);
            run_op(rct, rkey, model_decrypt(rct, rkey, 8'h00), $urandom_range(0, 3), "rand");
        end

        // Back-to-back stream with out_ready tied high
        ciphertext = 8'($urandom); key = 10'($urandom);
        in_valid = 1'b1; out_ready = 1'b1; last = -1;
        for (int c = 0; c < 120; c++) begin
            if (c >= 100) in_valid = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("b2b spurious out_valid", 1, 0);
                end else begin
                    exp_pt = q.pop_front();
                    check("b2b pt", plaintext, exp_pt);
                end
            end
            if (in_valid && in_ready) begin
                if (last >= 0) check("b2b interval", c - last, 5);
                last = c;
                q.push_back(model_decrypt(ciphertext, key, m_chain));
`ifdef SDES_DEC_CBC_EN
                m_chain = ciphertext;
`endif
            end else begin
                ciphertext = 8'($urandom);
                key        = 10'($urandom);
            end
            @(negedge CLOCK_50);
        end
        check("b2b drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
